binary_weight_streamer: RTL and testbench
=========================================

# binary_weight_streamer

Transmit side of the binary weight port feeding the fixed-activation binary dot-product and vector-mult blocks. Accepts fixed-point weight rows over a valid/ready stream and binarizes each element by sign into a local row buffer. Once the buffer holds NUM_ROWS rows, it replays them in order on a binary weight valid/ready stream NUM_REPEAT times, once per activation vector that reuses the tile, then returns to loading.

## Interface
- IN_WIDTH, 8: width of each signed fixed-point weight element on the load port.
- IN_SIZE, 4: elements per row; must equal the consumer's IN_SIZE.
- WEIGHT_WIDTH, 1: binary weight width. Fixed; do not modify.
- NUM_ROWS, 4: rows held in the buffer (≥1).
- NUM_REPEAT, 2: number of full passes over the buffer per load (≥1).
- clk  in  1  clock; all state updates on rising edge.
- rst  in  1  asynchronous, active-low reset.
- data_in  in  [IN_WIDTH-1:0] x IN_SIZE  signed fixed-point weight row.
- data_in_valid  in  1  load row valid.
- data_in_ready  out  1  load row ready.
- weight_out  out  [WEIGHT_WIDTH-1:0] x IN_SIZE  binary weight row.
- weight_out_valid  out  1  binary row valid.
- weight_out_ready  in  1  consumer ready.
- busy  out  1  high while in STREAM.

## Operation
- Binarization per element: bit = ~data_in[i][IN_WIDTH-1].
  - Sign bit 0 (value ≥ 0, including zero) gives 1, meaning +1.
  - Sign bit 1 gives 0, meaning −1.
- Storage: buffer[NUM_ROWS] of IN_SIZE bits. No other arithmetic is performed.
- FSM states: LOAD and STREAM.
- LOAD:
  - data_in_ready = 1; weight_out_valid = 0.
  - On each handshake, buffer[wr_ptr] <= binarized row and wr_ptr increments.
  - On the handshake with wr_ptr == NUM_ROWS-1: wr_ptr <= 0, state <= STREAM.
- STREAM:
  - data_in_ready = 0; weight_out_valid = 1; weight_out = buffer[rd_ptr] (combinational read).
  - On each output handshake, rd_ptr increments.
  - When rd_ptr == NUM_ROWS-1: rd_ptr wraps to 0 and rep_cnt increments.
  - On that wrap with rep_cnt == NUM_REPEAT-1: rep_cnt <= 0, state <= LOAD.
- Valid/ready rules:
  - weight_out_valid never deasserts without a handshake.
  - weight_out is stable while valid is high and ready is low.
  - data_in_valid and data_in are ignored outside LOAD.
- Reset (any time, including mid-load or mid-stream):
  - state = LOAD; wr_ptr, rd_ptr, rep_cnt = 0; buffer cleared to 0.
  - Outputs: data_in_ready = 1, weight_out_valid = 0, weight_out = 0, busy = 0.
  - A partially loaded or partially streamed tile is discarded.

## Timing
- Last load handshake at edge t: weight_out_valid = 1 in the cycle after t (1-cycle load-to-stream latency).
- Last output handshake of the final pass at edge t: data_in_ready = 1 in the cycle after t. No cycle has both data_in_ready and weight_out_valid high.
- Throughput:
  - LOAD: one row per cycle while data_in_valid holds.
  - STREAM: one row per cycle while weight_out_ready holds.
  - Full tile: NUM_ROWS + NUM_ROWS·NUM_REPEAT handshake cycles.
- Output-side backpressure stalls rd_ptr and rep_cnt indefinitely with no loss.
- NUM_ROWS = 1: every STREAM handshake is a wrap. NUM_REPEAT = 1: a single pass, then LOAD.
- Pointer widths: $clog2(NUM_ROWS) and $clog2(NUM_REPEAT), each with a minimum of 1.

## Structure
- Shared package binary_arith_pkg holds:
  - enum stream_state_t {LOAD, STREAM};
  - localparam BINARY_WEIGHT_WIDTH = 1;
  - the binarize encoding convention (1 = +1, 0 = −1), shared with the consumer blocks.
- One sub-module, fixed_binarize: combinational sign extraction of IN_SIZE elements, reusable by other binary blocks.
- Top level holds the FSM, pointers and buffer. Expected size about 150–200 lines.

## Test plan
- Reset, then load 4 rows with IN_SIZE=4, data_in rows {3,−1,0,−128}, {−5,7,−2,1}, {0,0,0,0}, {−1,−1,−1,−1} → weight_out rows 4'b0101 (element 0 as LSB), 4'b1010, 4'b1111, 4'b0000; the sequence is emitted twice; data_in_ready returns 1 one cycle after the 8th output handshake.
- Hold weight_out_ready = 0 for 5 cycles during row 2 of pass 1 → weight_out_valid stays 1, weight_out stays 4'b1111, and no row is skipped or repeated when ready resumes.
- Drive data_in_valid = 1 with garbage data throughout STREAM → no buffer change; output matches the loaded tile.
- Toggle data_in_valid randomly during LOAD → exactly 4 rows are captured, in handshake order.
- Assert rst low mid-stream (pass 1, row 1) → outputs immediately take reset values; a new load of all-positive rows then streams 4'b1111 ×8.
- Parameter sweep NUM_ROWS=1, NUM_REPEAT=1 → alternating single load and single output handshake; no cycle has both data_in_ready and weight_out_valid high.

Source files
------------

// File: rtl/binary_arith_pkg.sv
// rtl/binary_arith_pkg.sv - shared types and binary encoding for the binary weight blocks
package binary_arith_pkg;

    typedef enum logic {
        LOAD   = 1'b0,
        STREAM = 1'b1
    } stream_state_t;

    localparam int BINARY_WEIGHT_WIDTH = 1;

    // Binary encoding shared with the dot-product and vector-mult consumers.
    localparam logic BIN_POS = 1'b1;
    localparam logic BIN_NEG = 1'b0;

    function automatic logic binarize_sign(input logic sign_bit);
        return sign_bit ? BIN_NEG : BIN_POS;
    endfunction

    function automatic int ptr_width(input int depth);
        return (depth > 1) ? $clog2(depth) : 1;
    endfunction

endpackage

// File: rtl/fixed_binarize.sv
// rtl/fixed_binarize.sv - combinational sign-based binarization of a fixed-point row
module fixed_binarize
    import binary_arith_pkg::*;
#(
    parameter int IN_WIDTH = 8,
    parameter int IN_SIZE  = 4
) (
    input  logic [IN_SIZE-1:0][IN_WIDTH-1:0] data,
    output logic [IN_SIZE-1:0]               bits
);

    // Only the sign bits matter; the rest are folded here so they do not read as dangling.
    logic unused_magnitude;
    assign unused_magnitude = ^data;

    always_comb begin
        bits = '0;
        for (int i = 0; i < IN_SIZE; i++) begin
            bits[i] = binarize_sign(data[i][IN_WIDTH-1]);
        end
    end

endmodule

// File: rtl/binary_weight_streamer.sv
// rtl/binary_weight_streamer.sv - loads binarized weight rows, replays the tile NUM_REPEAT times
module binary_weight_streamer
    import binary_arith_pkg::*;
#(
    parameter int IN_WIDTH     = 8,
    parameter int IN_SIZE      = 4,
    parameter int WEIGHT_WIDTH = BINARY_WEIGHT_WIDTH,
    parameter int NUM_ROWS     = 4,
    parameter int NUM_REPEAT   = 2
) (
    input  logic                                 clk,
    input  logic                                 rst,
    input  logic [IN_SIZE-1:0][IN_WIDTH-1:0]     data_in,
    input  logic                                 data_in_valid,
    output logic                                 data_in_ready,
    output logic [IN_SIZE-1:0][WEIGHT_WIDTH-1:0] weight_out,
    output logic                                 weight_out_valid,
    input  logic                                 weight_out_ready,
    output logic                                 busy
);

    localparam int PTR_W = ptr_width(NUM_ROWS);
    localparam int REP_W = ptr_width(NUM_REPEAT);
    localparam logic [PTR_W-1:0] LAST_ROW = PTR_W'(NUM_ROWS - 1);
    localparam logic [REP_W-1:0] LAST_REP = REP_W'(NUM_REPEAT - 1);

    stream_state_t      state;
    logic [PTR_W-1:0]   wr_ptr;
    logic [PTR_W-1:0]   rd_ptr;
    logic [REP_W-1:0]   rep_cnt;
    logic [IN_SIZE-1:0] buffer [NUM_ROWS];
    logic [IN_SIZE-1:0] bin_row;
    logic [IN_SIZE-1:0] rd_row;

    fixed_binarize #(
        .IN_WIDTH (IN_WIDTH),
        .IN_SIZE  (IN_SIZE)
    ) u_binarize (
        .data (data_in),
        .bits (bin_row)
    );

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state   <= LOAD;
            wr_ptr  <= '0;
            rd_ptr  <= '0;
            rep_cnt <= '0;
            for (int i = 0; i < NUM_ROWS; i++) begin
                buffer[i] <= '0;
            end
        end else begin
            case (state)
                LOAD: begin
                    if (data_in_valid) begin
                        buffer[wr_ptr] <= bin_row;
                        if (wr_ptr == LAST_ROW) begin
                            wr_ptr <= '0;
                            state  <= STREAM;
                        end else begin
                            wr_ptr <= wr_ptr + PTR_W'(1);
                        end
                    end
                end
                STREAM: begin
                    // Backpressure simply holds rd_ptr/rep_cnt, so the current row stays on the bus.
                    if (weight_out_ready) begin
                        if (rd_ptr == LAST_ROW) begin
                            rd_ptr <= '0;
                            if (rep_cnt == LAST_REP) begin
                                rep_cnt <= '0;
                                state   <= LOAD;
                            end else begin
                                rep_cnt <= rep_cnt + REP_W'(1);
                            end
                        end else begin
                            rd_ptr <= rd_ptr + PTR_W'(1);
                        end
                    end
                end
                default: state <= LOAD;
            endcase
        end
    end

    assign data_in_ready    = (state == LOAD);
    assign weight_out_valid = (state == STREAM);
    assign busy             = (state == STREAM);
    assign rd_row           = buffer[rd_ptr];

    always_comb begin
        weight_out = '0;
        if (state == STREAM) begin
            for (int i = 0; i < IN_SIZE; i++) begin
                weight_out[i] = WEIGHT_WIDTH'(rd_row[i]);
            end
        end
    end

endmodule

// File: tb/tb_binary_weight_streamer.sv
// tb/tb_binary_weight_streamer.sv - randomized self-checking bench for binary_weight_streamer
module tb_binary_weight_streamer;

    localparam int IW    = 8;
    localparam int IS    = 4;
    localparam int NR    = 4;
    localparam int NP    = 2;
    localparam int TOTAL = NR * NP;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic                   rst;
    logic [IS-1:0][IW-1:0]  data_in;
    logic                   data_in_valid;
    logic                   data_in_ready;
    logic [IS-1:0][0:0]     weight_out;
    logic                   weight_out_valid;
    logic                   weight_out_ready;
    logic                   busy;

    logic [IS-1:0][IW-1:0]  d1_data;
    logic                   d1_valid;
    logic                   d1_ready;
    logic [IS-1:0][0:0]     d1_weight;
    logic                   d1_wvalid;
    logic                   d1_wready;
    logic                   d1_busy;

    binary_weight_streamer #(
        .IN_WIDTH(IW), .IN_SIZE(IS), .WEIGHT_WIDTH(1), .NUM_ROWS(NR), .NUM_REPEAT(NP)
    ) dut (
        .clk(clk), .rst(rst),
        .data_in(data_in), .data_in_valid(data_in_valid), .data_in_ready(data_in_ready),
        .weight_out(weight_out), .weight_out_valid(weight_out_valid),
        .weight_out_ready(weight_out_ready), .busy(busy)
    );

    binary_weight_streamer #(
        .IN_WIDTH(IW), .IN_SIZE(IS), .WEIGHT_WIDTH(1), .NUM_ROWS(1), .NUM_REPEAT(1)
    ) dut1 (
        .clk(clk), .rst(rst),
        .data_in(d1_data), .data_in_valid(d1_valid), .data_in_ready(d1_ready),
        .weight_out(d1_weight), .weight_out_valid(d1_wvalid),
        .weight_out_ready(d1_wready), .busy(d1_busy)
    );

    int checks   = 0;
    int failures = 0;

    logic signed [IW-1:0] tile [NR][IS];
    logic [IS-1:0]        exp_q [$];

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%0h expected=%0h", tag, got, exp);
        end
    endtask

    function automatic logic [IS-1:0] sign_row(input logic [IS-1:0][IW-1:0] row);
        logic [IS-1:0] r;
        for (int i = 0; i < IS; i++) r[i] = ($signed(row[i]) >= 0);
        return r;
    endfunction

    function automatic logic [IS-1:0][IW-1:0] tile_row(input int n);
        logic [IS-1:0][IW-1:0] r;
        for (int i = 0; i < IS; i++) r[i] = tile[n][i];
        return r;
    endfunction

    task automatic build_expect();
        exp_q.delete();
        for (int p = 0; p < NP; p++)
            for (int r = 0; r < NR; r++)
                exp_q.push_back(sign_row(tile_row(r)));
    endtask

    task automatic do_load();
        int n = 0;
        int cyc = 0;
        while (n < NR && cyc < 400) begin
            @(negedge clk);
            cyc++;
            check_eq("load_ready", data_in_ready, 1);
            check_eq("load_valid_low", weight_out_valid, 0);
            check_eq("load_busy", busy, 0);
            data_in_valid    = 1'($urandom_range(0, 1));
            weight_out_ready = 1'($urandom_range(0, 1));
            if (data_in_valid) begin
                data_in = tile_row(n);
                n++;
            end else begin
                data_in = $urandom;
            end
        end
        if (n < NR) check_eq("load_timeout", n, NR);
    endtask

    task automatic do_stream(input int stall_idx, input int stall_len, input int abort_at);
        int cnt = 0;
        int cyc = 0;
        int stall_left = stall_len;
        bit done = 0;
        while (!done && cyc < 600) begin
            @(negedge clk);
            cyc++;
            if (abort_at >= 0 && cnt == abort_at) begin
                rst = 1'b0;
                #1;
                check_eq("rst_mid_ready", data_in_ready, 1);
                check_eq("rst_mid_valid", weight_out_valid, 0);
                check_eq("rst_mid_weight", weight_out, 0);
                check_eq("rst_mid_busy", busy, 0);
                data_in_valid    = 1'b0;
                weight_out_ready = 1'b0;
                @(negedge clk);
                rst  = 1'b1;
                done = 1;
            end else if (cnt == TOTAL) begin
                check_eq("return_ready", data_in_ready, 1);
                check_eq("return_valid", weight_out_valid, 0);
                data_in_valid = 1'b0;
                done = 1;
            end else begin
                check_eq("stream_valid", weight_out_valid, 1);
                check_eq("stream_in_ready", data_in_ready, 0);
                check_eq("stream_busy", busy, 1);
                check_eq($sformatf("row%0d", cnt), weight_out, exp_q[cnt]);
                data_in_valid = 1'b1;
                data_in       = $urandom;
                if (cnt == stall_idx && stall_left > 0) begin
                    weight_out_ready = 1'b0;
                    stall_left--;
                end else begin
                    weight_out_ready = ($urandom_range(0, 3) != 0);
                end
                if (weight_out_ready) cnt++;
            end
        end
        if (!done) check_eq("stream_timeout", cnt, TOTAL);
    endtask

    task automatic set_directed_tile();
        tile[0] = '{8'sd3, -8'sd1, 8'sd0, -8'sd128};
        tile[1] = '{-8'sd5, 8'sd7, -8'sd2, 8'sd1};
        tile[2] = '{8'sd0, 8'sd0, 8'sd0, 8'sd0};
        tile[3] = '{-8'sd1, -8'sd1, -8'sd1, -8'sd1};
    endtask

    task automatic run_sweep();
        bit have = 0;
        logic [IS-1:0] saved = '0;
        for (int cyc = 0; cyc < 80; cyc++) begin
            @(negedge clk);
            check_eq("sw_exclusive", d1_ready & d1_wvalid, 0);
            if (!have) begin
                check_eq("sw_ready", d1_ready, 1);
                check_eq("sw_valid", d1_wvalid, 0);
            end else begin
                check_eq("sw_ready", d1_ready, 0);
                check_eq("sw_valid", d1_wvalid, 1);
                check_eq("sw_weight", d1_weight, saved);
            end
            d1_valid  = 1'($urandom_range(0, 1));
            d1_wready = 1'($urandom_range(0, 1));
            d1_data   = $urandom;
            if (!have && d1_valid) begin
                saved = sign_row(d1_data);
                have  = 1;
            end else if (have && d1_wready) begin
                have = 0;
            end
        end
    endtask

    initial begin
        rst              = 1'b0;
        data_in          = '0;
        data_in_valid    = 1'b0;
        weight_out_ready = 1'b0;
        d1_data          = '0;
        d1_valid         = 1'b0;
        d1_wready        = 1'b0;
        repeat (2) @(negedge clk);
        check_eq("reset_ready", data_in_ready, 1);
        check_eq("reset_valid", weight_out_valid, 0);
        check_eq("reset_weight", weight_out, 0);
        check_eq("reset_busy", busy, 0);
        check_eq("reset_d1_ready", d1_ready, 1);
        check_eq("reset_d1_valid", d1_wvalid, 0);
        rst = 1'b1;

        set_directed_tile();
        build_expect();
        do_load();
        do_stream(2, 5, -1);

        for (int t = 0; t < 3; t++) begin
            for (int r = 0; r < NR; r++)
                for (int i = 0; i < IS; i++)
                    tile[r][i] = IW'($urandom);
            build_expect();
            do_load();
            do_stream($urandom_range(0, TOTAL - 1), $urandom_range(0, 4), -1);
        end

        set_directed_tile();
        build_expect();
        do_load();
        do_stream(-1, 0, 1);

        for (int r = 0; r < NR; r++)
            for (int i = 0; i < IS; i++)
                tile[r][i] = IW'($urandom_range(0, 127));
        build_expect();
        do_load();
        do_stream(-1, 0, -1);

        run_sweep();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
